// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit feeding the register file write port.
// Shift-add multiply and restoring divide on operand magnitudes, one step per cycle.
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      rs1_val,
    input  logic [WIDTH-1:0]      rs2_val,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  kill,
    output logic                  busy,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [WIDTH-1:0]      wb_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_op;
    logic [ADDR_WIDTH-1:0]  r_rd;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opnd;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_we;
    logic [WIDTH-1:0]       r_wb_data;

    logic                   w_accept;
    logic                   w_a_signed;
    logic                   w_b_signed;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_div_zero;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_fast_data;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_diff;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_final;

    assign in_ready = (r_state == S_IDLE) && !rst;
    assign busy     = (r_state != S_IDLE);
    assign w_accept = in_valid && in_ready && !kill;
    assign wb_we    = r_we && !kill;
    assign wb_addr  = r_rd;
    assign wb_data  = r_wb_data;

    // Operand signedness, magnitudes and fast-path detection at accept.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (op)
            3'd1:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'd2:    begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            3'd4:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'd6:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default: begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_a_neg    = w_a_signed && rs1_val[WIDTH-1];
        w_b_neg    = w_b_signed && rs2_val[WIDTH-1];
        w_a_mag    = w_a_neg ? (~rs1_val + {{(WIDTH-1){1'b0}}, 1'b1}) : rs1_val;
        w_b_mag    = w_b_neg ? (~rs2_val + {{(WIDTH-1){1'b0}}, 1'b1}) : rs2_val;
        w_div_zero = op[2] && (rs2_val == {WIDTH{1'b0}});
        w_ovf      = ((op == 3'd4) || (op == 3'd6))
                     && (rs1_val == {1'b1, {(WIDTH-1){1'b0}}})
                     && (rs2_val == {WIDTH{1'b1}});
        if (w_div_zero) begin
            w_fast_data = op[1] ? rs1_val : {WIDTH{1'b1}};
        end else if (w_ovf) begin
            w_fast_data = op[1] ? {WIDTH{1'b0}} : rs1_val;
        end else begin
            w_fast_data = {WIDTH{1'b0}};
        end
    end

    // One multiply or divide step plus sign fix-up of the final result.
    always_comb begin
        // Multiply: high half accumulates, low half shifts out the multiplier.
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        // Divide: high half is the partial remainder, low half dividend/quotient.
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (!w_div_diff[WIDTH]) begin
            w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
        w_prod = r_neg_q ? (~w_mul_next + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_mul_next;
        w_quo  = r_neg_q ? (~w_div_next[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : w_div_next[WIDTH-1:0];
        w_rem  = r_neg_r ? (~w_div_next[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : w_div_next[2*WIDTH-1:WIDTH];
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else if (r_op == 3'd0) begin
            w_final = w_prod[WIDTH-1:0];
        end else begin
            w_final = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with operand, accumulator and write-back registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_op      <= 3'd0;
            r_rd      <= {ADDR_WIDTH{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_opnd    <= {WIDTH{1'b0}};
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_we      <= 1'b0;
            r_wb_data <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (w_accept) begin
                        r_op    <= op;
                        r_rd    <= rd;
                        r_cnt   <= {CW{1'b0}};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (w_div_zero || w_ovf) begin
                            r_wb_data <= w_fast_data;
                            r_we      <= (rd != {ADDR_WIDTH{1'b0}});
                            r_state   <= S_DONE;
                        end else if (op[2]) begin
                            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opnd  <= w_b_mag;
                            r_state <= S_CALC;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opnd  <= w_a_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        r_we    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        if (r_cnt == CNT_LAST) begin
                            r_wb_data <= w_final;
                            r_we      <= (r_rd != {ADDR_WIDTH{1'b0}});
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, fast path, kill and reset.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        kill = 1'b0;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .kill(kill),
        .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    // Issue one op at a negedge, then observe 40 cycles after the accept edge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, output int we_cyc, output int we_cnt,
                          output logic [31:0] data, output logic [4:0] addr,
                          output logic [63:0] rdy);
        op = f; rs1_val = a; rs2_val = b; rd = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        we_cyc = -1; we_cnt = 0; data = 32'd0; addr = 5'd0; rdy = 64'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            rdy[k] = in_ready;
            if (wb_we === 1'b1) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = k; data = wb_data; addr = wb_addr;
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rst_wb_we got %b want 0", wb_we); end
        total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL rst_wb_addr got %h want 0", wb_addr); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_mul_latency;
        int c, n; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, c, n, d, a, r);
        total++; if (c !== 33) begin bad++; $display("FAIL mul_we_cycle got %0d want 33", c); end
        total++; if (n !== 1) begin bad++; $display("FAIL mul_we_count got %0d want 1", n); end
        total++; if (d !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_data got %h want ffffffeb", d); end
        total++; if (a !== 5'd5) begin bad++; $display("FAIL mul_addr got %0d want 5", a); end
        total++; if (r[33:1] !== 33'd0) begin bad++; $display("FAIL mul_ready_busy got %h want 0", r[33:1]); end
        total++; if (r[34] !== 1'b1) begin bad++; $display("FAIL mul_ready_c34 got %b want 1", r[34]); end
    endtask

    task automatic test_mul_high;
        logic [2:0] fs[3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int c, n; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        for (int i = 0; i < 3; i++) begin
            run_op(fs[i], as[i], bs[i], 5'd6, c, n, d, a, r);
            total++; if (d !== es[i]) begin bad++; $display("FAIL mulh_data[%0d] got %h want %h", i, d, es[i]); end
            total++; if (c !== 33) begin bad++; $display("FAIL mulh_cycle[%0d] got %0d want 33", i, c); end
        end
    endtask

    task automatic test_div;
        logic [2:0] fs[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] es[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int c, n; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 5'd10, c, n, d, a, r);
            total++; if (d !== es[i]) begin bad++; $display("FAIL div_data[%0d] got %h want %h", i, d, es[i]); end
            total++; if (c !== 33) begin bad++; $display("FAIL div_cycle[%0d] got %0d want 33", i, c); end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0] fs[6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
        logic [31:0] as[6] = '{32'h55, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF0};
        logic [31:0] bs[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] es[6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
        int c, n; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        for (int i = 0; i < 6; i++) begin
            run_op(fs[i], as[i], bs[i], 5'd11, c, n, d, a, r);
            total++; if (d !== es[i]) begin bad++; $display("FAIL fast_data[%0d] got %h want %h", i, d, es[i]); end
            total++; if (c !== 1) begin bad++; $display("FAIL fast_cycle[%0d] got %0d want 1", i, c); end
            total++; if (r[2] !== 1'b1) begin bad++; $display("FAIL fast_ready[%0d] got %b want 1", i, r[2]); end
        end
    endtask

    task automatic test_rd_zero;
        int c, n; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        run_op(3'd0, 32'd3, 32'd4, 5'd0, c, n, d, a, r);
        total++; if (n !== 0) begin bad++; $display("FAIL rd0_we_count got %0d want 0", n); end
        total++; if (r[34] !== 1'b1) begin bad++; $display("FAIL rd0_idle got %b want 1", r[34]); end
    endtask

    task automatic test_kill_calc;
        int n = 0;
        op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5; rd = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (wb_we === 1'b1) n++;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL kill_ready got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy got %b want 0", busy); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (wb_we === 1'b1) n++;
        end
        total++; if (n !== 0) begin bad++; $display("FAIL kill_we_count got %0d want 0", n); end
    endtask

    task automatic test_kill_done;
        op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd0; rd = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL done_we got %b want 1", wb_we); end
        kill = 1'b1;
        #1;
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL done_kill_we got %b want 0", wb_we); end
        total++; if (wb_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL done_data got %h want ffffffff", wb_data); end
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL done_kill_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int c, m; logic [31:0] d; logic [4:0] a; logic [63:0] r;
        op = 3'd0; rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; rd = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wb_we === 1'b1) n++;
        end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL rstmid_addr got %h want 0", wb_addr); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rstmid_data got %h want 0", wb_data); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wb_we === 1'b1) n++;
        end
        total++; if (n !== 0) begin bad++; $display("FAIL rstmid_we_count got %0d want 0", n); end
        run_op(3'd5, 32'd100, 32'd7, 5'd9, c, m, d, a, r);
        total++; if (c !== 33) begin bad++; $display("FAIL rstmid_cycle got %0d want 33", c); end
        total++; if (d !== 32'd14) begin bad++; $display("FAIL rstmid_data2 got %h want 0000000e", d); end
        total++; if (a !== 5'd9) begin bad++; $display("FAIL rstmid_addr2 got %0d want 9", a); end
    endtask

    task automatic test_back_to_back;
        int p[2] = '{-1, -1};
        int idx = 0;
        logic [31:0] d1 = 32'd0;
        op = 3'd3; rs1_val = 32'h0001_0000; rs2_val = 32'h0003_0000; rd = 5'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (wb_we === 1'b1 && idx < 2) begin
                p[idx] = k;
                d1 = wb_data;
                idx++;
            end
        end
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (p[0] !== 33) begin bad++; $display("FAIL b2b_first got %0d want 33", p[0]); end
        total++; if (p[1] !== 67) begin bad++; $display("FAIL b2b_second got %0d want 67", p[1]); end
        total++; if (d1 !== 32'd3) begin bad++; $display("FAIL b2b_data got %h want 00000003", d1); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_div();
        test_fast_path();
        test_rd_zero();
        test_kill_calc();
        test_kill_done();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
